// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with saturating direction counters and zero-latency lookup.
// Optional gshare indexing of the direction counters is enabled by defining BTB_GSHARE_EN.
module branch_target_buffer #(
   parameter int ENTRIES = 16,
   parameter int ADDR_W  = 30,
   parameter int CNT_W   = 2,
   parameter int GHR_W   = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] if_pc,
   output logic              pred_hit,
   output logic              pred_taken,
   output logic [ADDR_W-1:0] pred_target,
   input  logic              upd_valid,
   input  logic [ADDR_W-1:0] upd_pc,
   input  logic              upd_taken,
   input  logic [ADDR_W-1:0] upd_target,
   input  logic              upd_cond,
   input  logic              inv_all
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = ADDR_W - IDX_W;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1) << (CNT_W - 1);
   localparam logic [CNT_W-1:0] CNT_WNT = CNT_WT - CNT_W'(1);

   if (ENTRIES < 2 || (ENTRIES & (ENTRIES - 1)) != 0) begin : g_bad_entries
      $error("ENTRIES must be a power of two and at least 2");
   end
   if (GHR_W < 1 || GHR_W > IDX_W) begin : g_bad_ghr
      $error("GHR_W must be between 1 and IDX_W");
   end

   logic              valid_q  [ENTRIES];
   logic [TAG_W-1:0]  tag_q    [ENTRIES];
   logic [ADDR_W-1:0] target_q [ENTRIES];
   logic              cond_q   [ENTRIES];
   logic [CNT_W-1:0]  cnt_q    [ENTRIES];

   logic [IDX_W-1:0] lk_idx, up_idx, lk_cidx, up_cidx;
   logic [TAG_W-1:0] lk_tag, up_tag;
   logic             up_hit;
   logic [CNT_W-1:0] cnt_cur, cnt_sat;

   assign lk_idx = if_pc[IDX_W-1:0];
   assign lk_tag = if_pc[ADDR_W-1:IDX_W];
   assign up_idx = upd_pc[IDX_W-1:0];
   assign up_tag = upd_pc[ADDR_W-1:IDX_W];

`ifdef BTB_GSHARE_EN
   logic [GHR_W-1:0] ghr_q;
   logic [GHR_W:0]   ghr_shift;

   // Counters live in a pattern table hashed with global history.
   assign lk_cidx   = lk_idx ^ IDX_W'(ghr_q);
   assign up_cidx   = up_idx ^ IDX_W'(ghr_q);
   assign ghr_shift = {ghr_q, upd_taken};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ghr_q <= '0;
      end else if (inv_all) begin
         ghr_q <= '0;
      end else if (upd_valid && upd_cond) begin
         ghr_q <= ghr_shift[GHR_W-1:0];
      end
   end
`else
   assign lk_cidx = lk_idx;
   assign up_cidx = up_idx;
`endif

   assign pred_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
   assign pred_taken  = pred_hit && (!cond_q[lk_idx] || cnt_q[lk_cidx][CNT_W-1]);
   assign pred_target = pred_taken ? target_q[lk_idx] : if_pc + ADDR_W'(1);

   assign up_hit  = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
   assign cnt_cur = cnt_q[up_cidx];

   always_comb begin
      cnt_sat = cnt_cur;
      if (upd_taken) begin
         if (cnt_cur != CNT_MAX) cnt_sat = cnt_cur + CNT_W'(1);
      end else if (cnt_cur != '0) begin
         cnt_sat = cnt_cur - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            cond_q[i]   <= 1'b0;
            cnt_q[i]    <= CNT_WNT;
         end
      end else if (inv_all) begin
         // Counters keep their training across a context change.
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
         end
      end else if (upd_valid) begin
         if (up_hit) begin
            if (upd_cond) begin
               cnt_q[up_cidx] <= cnt_sat;
               if (upd_taken) target_q[up_idx] <= upd_target;
            end else begin
               cnt_q[up_cidx]   <= CNT_MAX;
               target_q[up_idx] <= upd_target;
               cond_q[up_idx]   <= 1'b0;
            end
         end else if (upd_taken) begin
            valid_q[up_idx]  <= 1'b1;
            tag_q[up_idx]    <= up_tag;
            target_q[up_idx] <= upd_target;
            cond_q[up_idx]   <= upd_cond;
            cnt_q[up_cidx]   <= upd_cond ? CNT_WT : CNT_MAX;
         end
      end
   end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed bench for branch_target_buffer: a vector table of lookups/updates plus reset corner sequences.
module tb_branch_target_buffer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [29:0] if_pc = '0;
   logic        pred_hit, pred_taken;
   logic [29:0] pred_target;
   logic        upd_valid = 1'b0;
   logic [29:0] upd_pc = '0;
   logic        upd_taken = 1'b0;
   logic [29:0] upd_target = '0;
   logic        upd_cond = 1'b0;
   logic        inv_all = 1'b0;

   int n_total = 0;
   int n_pass  = 0;

   branch_target_buffer #(.ENTRIES(16), .ADDR_W(30), .CNT_W(2), .GHR_W(4)) dut (
      .clk(clk), .rst(rst), .if_pc(if_pc),
      .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
      .upd_target(upd_target), .upd_cond(upd_cond), .inv_all(inv_all)
   );

   always #5 clk = ~clk;

   // Lookup expectations reflect state before this step's update lands on the next rising edge.
   typedef struct {
      logic        uv;
      logic [29:0] upc;
      logic        ut;
      logic [29:0] utgt;
      logic        uc;
      logic        inv;
      logic [29:0] lpc;
      logic        e_hit;
      logic        e_taken;
      logic [29:0] e_tgt;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input int step, input logic [29:0] act, input logic [29:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
   endtask

   task automatic add(input logic uv, input logic [29:0] upc, input logic ut, input logic [29:0] utgt,
                      input logic uc, input logic inv, input logic [29:0] lpc,
                      input logic eh, input logic et, input logic [29:0] etg);
      vec_t v;
      v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt; v.uc = uc; v.inv = inv;
      v.lpc = lpc; v.e_hit = eh; v.e_taken = et; v.e_tgt = etg;
      vecs.push_back(v);
   endtask

   initial begin
      //   uv  upc    ut  utgt   uc inv lpc            hit tk  target
      add(0, 'h000, 0, 'h000, 0, 0, 'h100,         0, 0, 'h101);
      add(1, 'h100, 1, 'h200, 1, 0, 'h100,         0, 0, 'h101);
      add(0, 'h000, 0, 'h000, 0, 0, 'h100,         1, 1, 'h200);
      add(1, 'h100, 0, 'h999, 1, 0, 'h100,         1, 1, 'h200);
      add(1, 'h100, 0, 'h999, 1, 0, 'h100,         1, 0, 'h101);
      add(1, 'h100, 0, 'h999, 1, 0, 'h100,         1, 0, 'h101);
      add(1, 'h100, 1, 'h200, 1, 0, 'h100,         1, 0, 'h101);
      add(1, 'h100, 1, 'h200, 1, 0, 'h100,         1, 0, 'h101);
      add(0, 'h000, 0, 'h000, 0, 0, 'h100,         1, 1, 'h200);
      add(0, 'h000, 0, 'h000, 0, 0, 'h110,         0, 0, 'h111);
      add(1, 'h110, 1, 'h300, 1, 0, 'h110,         0, 0, 'h111);
      add(0, 'h000, 0, 'h000, 0, 0, 'h100,         0, 0, 'h101);
      add(0, 'h000, 0, 'h000, 0, 0, 'h110,         1, 1, 'h300);
      add(1, 'h120, 0, 'h555, 1, 0, 'h110,         1, 1, 'h300);
      add(0, 'h000, 0, 'h000, 0, 0, 'h120,         0, 0, 'h121);
      add(0, 'h000, 0, 'h000, 0, 0, 'h110,         1, 1, 'h300);
      add(1, 'h040, 1, 'h080, 0, 0, 'h040,         0, 0, 'h041);
      add(0, 'h000, 0, 'h000, 0, 0, 'h040,         1, 1, 'h080);
      add(1, 'h050, 1, 'h090, 1, 1, 'h040,         1, 1, 'h080);
      add(0, 'h000, 0, 'h000, 0, 0, 'h040,         0, 0, 'h041);
      add(0, 'h000, 0, 'h000, 0, 0, 'h050,         0, 0, 'h051);
      add(0, 'h000, 0, 'h000, 0, 0, 30'h3FFFFFFF,  0, 0, 'h000);
      add(1, 'h007, 1, 'h033, 1, 0, 'h007,         0, 0, 'h008);
      add(0, 'h000, 0, 'h000, 0, 0, 'h007,         1, 1, 'h033);
      add(0, 'h000, 0, 'h000, 0, 0, 'h017,         0, 0, 'h018);
      add(1, 'h007, 1, 'h044, 0, 0, 'h007,         1, 1, 'h033);
      add(1, 'h007, 0, 'h999, 1, 0, 'h007,         1, 1, 'h044);
      add(1, 'h007, 0, 'h999, 1, 0, 'h007,         1, 1, 'h044);
      add(0, 'h000, 0, 'h000, 0, 0, 'h007,         1, 1, 'h044);

      repeat (2) @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i]) begin
         @(negedge clk);
         upd_valid  = vecs[i].uv;
         upd_pc     = vecs[i].upc;
         upd_taken  = vecs[i].ut;
         upd_target = vecs[i].utgt;
         upd_cond   = vecs[i].uc;
         inv_all    = vecs[i].inv;
         if_pc      = vecs[i].lpc;
         #1;
         chk("hit",    i, 30'(pred_hit),   30'(vecs[i].e_hit));
         chk("taken",  i, 30'(pred_taken), 30'(vecs[i].e_taken));
         chk("target", i, pred_target,     vecs[i].e_tgt);
      end

      // Async reset between edges with an update pending: entry 0x7 vanishes at once.
      @(negedge clk);
      upd_valid = 1'b1; upd_pc = 'h007; upd_taken = 1'b1; upd_target = 'h066; upd_cond = 1'b0;
      inv_all = 1'b0; if_pc = 'h007;
      #1;
      chk("pre_rst_hit", 100, 30'(pred_hit), 30'(1'b1));
      rst = 1'b1;
      #1;
      chk("async_rst_hit", 101, 30'(pred_hit), 30'(1'b0));
      chk("async_rst_target", 101, pred_target, 'h008);
      @(negedge clk);
      rst = 1'b0; upd_valid = 1'b0;
      #1;
      chk("rst_drop_upd_hit", 102, 30'(pred_hit), 30'(1'b0));

      // After reset the counter is weakly not-taken: one taken step of a fresh entry gives weakly taken,
      // and a single not-taken then drops prediction.
      upd_valid = 1'b1; upd_pc = 'h00A; upd_taken = 1'b1; upd_target = 'h0AA; upd_cond = 1'b1; if_pc = 'h00A;
      @(negedge clk);
      upd_taken = 1'b0;
      #1;
      chk("alloc_taken", 103, 30'(pred_taken), 30'(1'b1));
      @(negedge clk);
      upd_valid = 1'b0;
      #1;
      chk("weak_drop_taken", 104, 30'(pred_taken), 30'(1'b0));
      chk("weak_drop_target", 104, pred_target, 'h00B);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
